priority_irq_encoder: RTL and testbench

PRIORITY_IRQ_ENCODER -- requirements
Module: priority_irq_encoder

---
 rtl/priority_irq_encoder.sv | 127 ++++++++++++
 tb/tb_priority_irq_encoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/priority_irq_encoder.sv
// Edge-captured interrupt priority encoder with a registered valid/ready output stage.
// Define ROUND_ROBIN_EN for rotating-priority arbitration; otherwise the highest index wins.
module priority_irq_encoder #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_valid,
    output logic [N-1:0]         pending
);
    localparam int W = $clog2(N);

    // Handshake: a grant transfers on a rising edge where out_valid && out_ready;
    // out_idx/out_valid hold steady while out_valid && !out_ready.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   req_q, req_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   out_idx_q, out_idx_d;
    logic           armed_q, armed_d;

    logic           handshake;
    logic [N-1:0]   rise;
    logic [N-1:0]   grant_mask;
    logic [N-1:0]   cand;
    logic [W-1:0]   pick_idx;
    logic           pick_found;

    // armed_q keeps lines already high across reset release from looking like rising edges.
    always_comb begin
        handshake  = (state_q == PRESENT) && out_ready;
        rise       = armed_q ? (req & ~req_q) : '0;
        grant_mask = '0;
        if (handshake) begin
            grant_mask[out_idx_q] = 1'b1;
        end
        cand = pending_q & mask & ~grant_mask;
    end

    always_comb begin
        req_d     = req;
        armed_d   = 1'b1;
        pending_d = (pending_q & ~grant_mask) | rise;
    end

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] last_q, last_d;

    // Search descends from last-1 and wraps, so the last winner has lowest priority.
    always_comb begin
        last_d     = handshake ? out_idx_q : last_q;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!pick_found && cand[(int'(last_d) + N - k) % N]) begin
                pick_idx   = W'((int'(last_d) + N - k) % N);
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                pick_idx   = W'(i);
                pick_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = PRESENT;
            PRESENT: if (handshake && !pick_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_idx_d = out_idx_q;
        if ((state_q == IDLE) || handshake) begin
            out_idx_d = pick_idx;
        end
    end

    always_comb begin
        out_valid = (state_q == PRESENT);
        out_idx   = out_idx_q;
        pending   = pending_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            out_idx_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            out_idx_q <= out_idx_d;
            armed_q   <= armed_d;
        end
    end
endmodule

// File: tb/tb_priority_irq_encoder.sv
// Directed bench for priority_irq_encoder (N=8); grant order tracked in a scoreboard queue.
module tb_priority_irq_encoder;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic [N-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    priority_irq_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .pending   (pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag);
        logic [W-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_idx"}, 32'(out_idx), 32'(e));
    endtask

    initial begin
        rst = 1'b1; req = '0; mask = 8'hFF; out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        tick();

        // Two lines rise together: 5 then 2 back-to-back
        req = 8'h24; out_ready = 1'b1;
        exp_q.push_back(3'd5); exp_q.push_back(3'd2);
        tick();
        check("cap_pending", 32'(pending), 32'h24);
        check("cap_valid", 32'(out_valid), 32'd0);
        tick(); expect_grant("b2b_first");
        tick(); expect_grant("b2b_second");
        tick();
        check("b2b_done_valid", 32'(out_valid), 32'd0);
        check("b2b_done_pending", 32'(pending), 32'h00);
        tick();
        check("held_no_reset", 32'(pending), 32'h00);

        // Hold under back-pressure while a higher line arrives
        req = 8'h00; out_ready = 1'b0; tick();
        req = 8'h04; tick(); tick();
        check("hold_idx_pre", 32'(out_idx), 32'd2);
        req = 8'h84; tick();
        check("hold_idx", 32'(out_idx), 32'd2);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pending", 32'(pending), 32'h84);
        tick();
        check("hold_idx2", 32'(out_idx), 32'd2);
        out_ready = 1'b1;
        exp_q.push_back(3'd2); exp_q.push_back(3'd7);
        expect_grant("hold_accept");
        tick(); expect_grant("hold_next");
        tick();
        check("hold_done_valid", 32'(out_valid), 32'd0);

        // Masked pending line survives and is granted after unmasking
        req = 8'h00; tick();
        mask = 8'hBF; req = 8'h40; tick(); tick();
        check("mask_valid", 32'(out_valid), 32'd0);
        check("mask_pending", 32'(pending), 32'h40);
        mask = 8'hFF; exp_q.push_back(3'd6); tick();
        expect_grant("unmask");
        tick();
        check("unmask_done", 32'(pending), 32'h00);

        // New event on the same edge as its own handshake
        req = 8'h00; out_ready = 1'b0; tick();
        req = 8'h08; tick(); tick();
        check("setclr_pre_idx", 32'(out_idx), 32'd3);
        req = 8'h00; tick();
        out_ready = 1'b1; req = 8'h08; tick();
        check("setclr_pending", 32'(pending), 32'h08);
        check("setclr_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(3'd3); tick();
        expect_grant("setclr_again");
        tick();
        check("setclr_done", 32'(pending), 32'h00);

        // Arbitration mode: last grant 7, then {7,3} pending from IDLE
        req = 8'h00; mask = 8'h80; tick();
        req = 8'h88; tick(); tick();
        exp_q.push_back(3'd7);
        expect_grant("arb_first");
        tick();
        check("arb_idle", 32'(out_valid), 32'd0);
        check("arb_left", 32'(pending), 32'h08);
        req = 8'h08; tick();
        req = 8'h88; tick();
        check("arb_repulse", 32'(pending), 32'h88);
        mask = 8'hFF;
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(3'd3); exp_q.push_back(3'd7);
`else
        exp_q.push_back(3'd7); exp_q.push_back(3'd3);
`endif
        tick(); expect_grant("arb_second");
        tick(); expect_grant("arb_third");
        tick();
        check("arb_done", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with a grant about to transfer
        req = 8'h00; out_ready = 1'b0; tick();
        req = 8'h24; tick(); tick();
        check("areset_pre", 32'(pending), 32'h24);
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_idx", 32'(out_idx), 32'd0);
        check("areset_pending", 32'(pending), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("release_pending", 32'(pending), 32'd0);
        check("release_valid", 32'(out_valid), 32'd0);
        req = 8'h25; tick();
        check("release_live", 32'(pending), 32'h01);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
